// File: rtl/ext_pkg.sv
//------------------------------------------------------------------------------
// Module   : ext_pkg
// Purpose  : Mode encodings shared by the registered immediate/load extender.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ext_pkg;

    localparam int EXT_MODE_W = 3;

    localparam logic [EXT_MODE_W-1:0] EXT_ZERO = 3'd0;
    localparam logic [EXT_MODE_W-1:0] EXT_SIGN = 3'd1;
    localparam logic [EXT_MODE_W-1:0] EXT_LUI  = 3'd2;
    localparam logic [EXT_MODE_W-1:0] EXT_BOFF = 3'd3;
    localparam logic [EXT_MODE_W-1:0] EXT_LB   = 3'd4;
    localparam logic [EXT_MODE_W-1:0] EXT_LBU  = 3'd5;
    localparam logic [EXT_MODE_W-1:0] EXT_LH   = 3'd6;
    localparam logic [EXT_MODE_W-1:0] EXT_LHU  = 3'd7;

endpackage

`default_nettype wire

// File: rtl/ext_core.sv
//------------------------------------------------------------------------------
// Module   : ext_core
// Purpose  : Combinational mode -> extended data plus illegal-item flag.
//            Load modes exist only when EXT_LOAD_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ext_core
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic [EXT_MODE_W-1:0]        mode_i,
    input  logic [IMM_W-1:0]             imm_i,
    input  logic [DATA_W-1:0]            word_i,
    input  logic [$clog2(DATA_W/8)-1:0]  off_i,
    output logic [DATA_W-1:0]            data_o,
    output logic                         illegal_o
);

    localparam int OFF_W = $clog2(DATA_W/8);

    logic [DATA_W-1:0] w_sext;
    assign w_sext = DATA_W'($signed(imm_i));

`ifdef EXT_LOAD_EN
    logic [OFF_W-1:0] w_half_off;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;

    // Halfword lanes are addressed on even offsets; misaligned offsets are flagged below.
    always_comb begin
        w_half_off    = off_i;
        w_half_off[0] = 1'b0;
    end

    assign w_byte = 8'(word_i >> {off_i, 3'b000});
    assign w_half = 16'(word_i >> {w_half_off, 3'b000});
`else
    logic w_unused_load;
    assign w_unused_load = ^{word_i, off_i};
`endif

    always_comb begin
        data_o    = '0;
        illegal_o = 1'b0;
        case (mode_i)
            EXT_ZERO: data_o = DATA_W'(imm_i);
            EXT_SIGN: data_o = w_sext;
            EXT_LUI:  data_o = DATA_W'(imm_i) << (DATA_W - IMM_W);
            EXT_BOFF: data_o = w_sext << 2;
`ifdef EXT_LOAD_EN
            EXT_LB:   data_o = DATA_W'($signed(w_byte));
            EXT_LBU:  data_o = DATA_W'(w_byte);
            EXT_LH: begin
                if (off_i[0]) illegal_o = 1'b1;
                else          data_o    = DATA_W'($signed(w_half));
            end
            EXT_LHU: begin
                if (off_i[0]) illegal_o = 1'b1;
                else          data_o    = DATA_W'(w_half);
            end
`endif
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ext_pipe.sv
//------------------------------------------------------------------------------
// Module   : ext_pipe
// Purpose  : One-stage registered extender with valid/ready, flush and sticky
//            err. Load modes 4-7 are built only when EXT_LOAD_EN is defined.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module ext_pipe
    import ext_pkg::*;
#(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 5
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [EXT_MODE_W-1:0]        in_mode,
    input  logic [IMM_W-1:0]             in_imm,
    input  logic [DATA_W-1:0]            in_word,
    input  logic [$clog2(DATA_W/8)-1:0]  in_off,
    input  logic [TAG_W-1:0]             in_tag,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic [TAG_W-1:0]             out_tag,
    output logic                         err
);

    logic [DATA_W-1:0] w_core_data;
    logic              w_core_illegal;
    logic              w_accept;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;
    logic              err_q,       err_d;

    ext_core #(
        .IMM_W  (IMM_W),
        .DATA_W (DATA_W)
    ) u_core (
        .mode_i    (in_mode),
        .imm_i     (in_imm),
        .word_i    (in_word),
        .off_i     (in_off),
        .data_o    (w_core_data),
        .illegal_o (w_core_illegal)
    );

    assign in_ready = !out_valid_q | out_ready;
    assign w_accept = in_valid & in_ready & !flush;

    // Flush outranks accept, so an item killed in its accept cycle never reaches err.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        err_d       = err_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_accept) begin
            out_valid_d = 1'b1;
            out_data_d  = w_core_illegal ? '0 : w_core_data;
            out_tag_d   = in_tag;
            err_d       = err_q | w_core_illegal;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign err       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_ext_pipe.sv
//------------------------------------------------------------------------------
// Module   : tb_ext_pipe
// Purpose  : Self-checking bench for ext_pipe (directed + randomized streams,
//            with or without EXT_LOAD_EN).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_ext_pipe;
    import ext_pkg::*;

    localparam int IMM_W  = 16;
    localparam int DATA_W = 32;
    localparam int TAG_W  = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_mode;
    logic [IMM_W-1:0]  in_imm;
    logic [DATA_W-1:0] in_word;
    logic [1:0]        in_off;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TAG_W-1:0]  out_tag;
    logic              err;

    int errors = 0;
    int checks = 0;

    // Behavioural expectation of the visible output state
    logic        m_valid = 1'b0;
    logic [31:0] m_data  = '0;
    logic [4:0]  m_tag   = '0;
    logic        m_err   = 1'b0;

    always #5 clk = ~clk;

    ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_imm(in_imm), .in_word(in_word), .in_off(in_off), .in_tag(in_tag),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .err(err)
    );

    // Spec rules as plain arithmetic on integers
    function automatic logic [31:0] ref_ext(input logic [2:0] m, input logic [15:0] imm,
                                            input logic [31:0] w, input logic [1:0] off,
                                            output logic ill);
        longint s, lw, r;
        ill = 1'b0;
        r   = 0;
        s   = longint'(imm);
        if (s >= 32768) s = s - 65536;
        lw = longint'(w);
        for (int k = 0; k < int'(off); k++) lw = lw / 256;
        case (int'(m))
            0: r = longint'(imm);
            1: r = s;
            2: r = longint'(imm) * 65536;
            3: r = s * 4;
            default: begin
`ifdef EXT_LOAD_EN
                if (m == 3'd4 || m == 3'd5) begin
                    r = lw % 256;
                    if (m == 3'd4 && r >= 128) r = r - 256;
                end else if ((int'(off) % 2) != 0) begin
                    ill = 1'b1;
                end else begin
                    r = lw % 65536;
                    if (m == 3'd6 && r >= 32768) r = r - 65536;
                end
`else
                ill = 1'b1;
`endif
            end
        endcase
        return 32'(r);
    endfunction

    task automatic drive(input logic v, input logic [2:0] mode, input logic [15:0] imm,
                         input logic [31:0] word, input logic [1:0] off, input logic [4:0] tag,
                         input logic fl, input logic ordy);
        in_valid = v; in_mode = mode; in_imm = imm; in_word = word;
        in_off = off; in_tag = tag; flush = fl; out_ready = ordy;
    endtask

    // Apply the driven inputs across one rising edge and update the expectation.
    task automatic advance();
        logic        rdy, ill;
        logic [31:0] d;
        rdy = !m_valid || out_ready;
        d   = ref_ext(in_mode, in_imm, in_word, in_off, ill);
        if (flush) begin
            m_valid = 1'b0;
        end else if (in_valid && rdy) begin
            m_valid = 1'b1;
            m_data  = ill ? 32'd0 : d;
            m_tag   = in_tag;
            if (ill) m_err = 1'b1;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(0, EXT_ZERO, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL reset_data: got %h want 0", out_data); end
        checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL reset_tag: got %h want 0", out_tag); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        reset_n = 1'b1;
        m_valid = 0; m_data = 0; m_tag = 0; m_err = 0;
    endtask

    task automatic test_modes();
        logic [2:0]  modes [4] = '{EXT_SIGN, EXT_ZERO, EXT_LUI, EXT_BOFF};
        logic [15:0] imms  [4] = '{16'h8001, 16'h8001, 16'h1234, 16'hFFFF};
        logic [31:0] exps  [4] = '{32'hFFFF8001, 32'h00008001, 32'h12340000, 32'hFFFFFFFC};
        for (int i = 0; i < 4; i++) begin
            drive(1, modes[i], imms[i], 32'd0, 2'd0, 5'd17, 0, 1);
            advance();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mode%0d_valid: got %b want 1", i, out_valid); end
            checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL mode%0d_data: got %h want %h", i, out_data, exps[i]); end
            checks++; if (out_tag !== 5'd17) begin errors++; $display("FAIL mode%0d_tag: got %0d want 17", i, out_tag); end
        end
        drive(0, EXT_ZERO, 0, 0, 0, 0, 0, 1);
        advance();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_stall_back_to_back();
        drive(1, EXT_SIGN, 16'h7ABC, 0, 0, 5'd3, 0, 0);
        advance();
        for (int c = 0; c < 3; c++) begin
            drive(1, EXT_ZERO, 16'($urandom), 0, 0, 5'd30, 0, 0);
            #1;
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready: got %b want 0", in_ready); end
            advance();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b want 1", out_valid); end
            checks++; if (out_data !== 32'h00007ABC) begin errors++; $display("FAIL stall_data: got %h want 00007abc", out_data); end
            checks++; if (out_tag !== 5'd3) begin errors++; $display("FAIL stall_tag: got %0d want 3", out_tag); end
        end
        for (int i = 0; i < 6; i++) begin
            drive(1, 3'($urandom_range(0, 3)), 16'($urandom), 0, 0, 5'(i + 8), 0, 1);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
            advance();
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", out_valid); end
            checks++; if (out_tag !== 5'(i + 8)) begin errors++; $display("FAIL b2b_tag: got %0d want %0d", out_tag, i + 8); end
            checks++; if (out_data !== m_data) begin errors++; $display("FAIL b2b_data: got %h want %h", out_data, m_data); end
        end
        drive(0, EXT_ZERO, 0, 0, 0, 0, 0, 1);
        advance();
    endtask

    task automatic test_flush();
        drive(1, EXT_SIGN, 16'h0001, 0, 0, 5'd4, 0, 0);
        advance();
        drive(1, EXT_LHU, 16'h0000, 32'hDEADBEEF, 2'd1, 5'd9, 1, 0);
        advance();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b want 0", err); end
        drive(0, EXT_ZERO, 0, 0, 0, 0, 0, 1);
        advance();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_lost: got %b want 0", out_valid); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive(($urandom % 4) != 0, 3'($urandom), 16'($urandom), $urandom, 2'($urandom),
                  5'($urandom), ($urandom % 12) == 0, ($urandom % 3) != 0);
            #1;
            checks++; if (in_ready !== (!m_valid || out_ready)) begin errors++; $display("FAIL rnd_ready: got %b want %b", in_ready, !m_valid || out_ready); end
            advance();
            checks++; if (out_valid !== m_valid) begin errors++; $display("FAIL rnd_valid: got %b want %b", out_valid, m_valid); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_err: got %b want %b", err, m_err); end
            if (m_valid) begin
                checks++; if (out_data !== m_data) begin errors++; $display("FAIL rnd_data: got %h want %h", out_data, m_data); end
                checks++; if (out_tag !== m_tag) begin errors++; $display("FAIL rnd_tag: got %0d want %0d", out_tag, m_tag); end
            end
        end
    endtask

    task automatic test_load_err();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_valid = 0; m_data = 0; m_tag = 0; m_err = 0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ld_err_clear: got %b want 0", err); end
`ifdef EXT_LOAD_EN
        begin
            logic [2:0]  modes [3] = '{EXT_LB, EXT_LBU, EXT_LH};
            logic [1:0]  offs  [3] = '{2'd2, 2'd3, 2'd2};
            logic [31:0] exps  [3] = '{32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF};
            for (int i = 0; i < 3; i++) begin
                drive(1, modes[i], 0, 32'h80FF7F01, offs[i], 5'(i), 0, 1);
                advance();
                checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL load%0d_data: got %h want %h", i, out_data, exps[i]); end
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL load%0d_err: got %b want 0", i, err); end
            end
        end
        drive(1, EXT_LHU, 0, 32'h80FF7F01, 2'd1, 5'd21, 0, 1);
`else
        drive(1, EXT_LB, 0, 32'h80FF7F01, 2'd0, 5'd21, 0, 1);
`endif
        advance();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ill_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL ill_data: got %h want 0", out_data); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL ill_err: got %b want 1", err); end
        drive(1, EXT_ZERO, 16'h0042, 0, 0, 5'd1, 1, 0);
        advance();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ill_flush_valid: got %b want 0", out_valid); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_async_reset();
        drive(1, EXT_SIGN, 16'h0055, 0, 0, 5'd2, 0, 0);
        advance();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_hold_valid: got %b want 1", out_valid); end
        drive(0, EXT_ZERO, 0, 0, 0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'd0) begin errors++; $display("FAIL ar_data: got %h want 0", out_data); end
        checks++; if (out_tag !== 5'd0) begin errors++; $display("FAIL ar_tag: got %0d want 0", out_tag); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL ar_err: got %b want 0", err); end
        @(negedge clk);
        reset_n = 1'b1;
        m_valid = 0; m_data = 0; m_tag = 0; m_err = 0;
        drive(1, EXT_LUI, 16'hBEEF, 0, 0, 5'd31, 0, 1);
        advance();
        checks++; if (out_data !== 32'hBEEF0000) begin errors++; $display("FAIL ar_after_data: got %h want beef0000", out_data); end
        checks++; if (out_tag !== 5'd31) begin errors++; $display("FAIL ar_after_tag: got %0d want 31", out_tag); end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_stall_back_to_back();
        test_flush();
        test_random();
        test_load_err();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ext_pipe.md
Name: ext_pipe

Overview:
- Parametrised, registered successor to the single-cycle immediate extender, for the pipelined datapath.
- Takes an immediate or load word, an extension mode and a destination tag, and produces the extended value one cycle later.
- Uses a valid/ready handshake with stall and flush support.
- Sits between decode/EX (immediate path) or MEM/WB (load-data path) and the next pipeline register.

Parameters:
- IMM_W, 16: immediate width; must satisfy IMM_W <= DATA_W-2.
- DATA_W, 32: datapath width; a multiple of 8 and at least 16.
- TAG_W, 5: width of the sideband tag (destination register number) carried with each item.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream item present.
- in_ready  out  1  block can accept an item this cycle.
- in_mode  in  3  extension mode, encoded as listed under Behaviour.
- in_imm  in  IMM_W  immediate source.
- in_word  in  DATA_W  load-word source (load modes only).
- in_off  in  $clog2(DATA_W/8)  byte offset within in_word.
- in_tag  in  TAG_W  sideband tag, passed through unchanged.
- flush  in  1  synchronous kill of the held item.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts.
- out_data  out  DATA_W  extended result.
- out_tag  out  TAG_W  tag of the result.
- err  out  1  sticky error flag.

Behaviour:
- Mode encoding:
  - 0 ZERO: zero-extend in_imm.
  - 1 SIGN: sign-extend in_imm.
  - 2 LUI: in_imm placed in bits [DATA_W-1 : DATA_W-IMM_W], lower bits 0.
  - 3 BOFF: sign-extend in_imm, then shift left by 2 (branch offset); bits above DATA_W are dropped.
  - 4 LB, 5 LBU, 6 LH, 7 LHU: select byte/halfword lane in_off of in_word, then sign- or zero-extend.
- Single register stage, latency exactly 1 cycle.
- in_ready = !out_valid | out_ready, combinational. No other combinational path from in_* to out_*.
- Accept occurs when in_valid & in_ready. On the next edge: out_valid=1; out_data/out_tag are loaded with the computed result.
- Hold: when out_valid & !out_ready, out_data, out_tag and out_valid hold stable.
- Drain: out_ready with no accept gives out_valid=0 on the next edge.
- Simultaneous drain and accept in one cycle is allowed; throughput is 1 item per cycle.
- Flush: on the next edge out_valid=0, and any item presented in the same cycle is discarded. Flush has priority over accept. err is not affected.
- Reset (asserted asynchronously, including mid-transfer): out_valid=0, out_data=0, out_tag=0, err=0. Output is held at these values until the first edge after release.
- Error conditions set err at the accept edge; err stays set until reset. The affected item still issues, with out_data=0.
  - A load mode when the load feature is compiled out.
  - LH/LHU with in_off[0]=1 (misaligned halfword).
- The err event is counted only for accepted items. An item killed by flush in its accept cycle does not set err.
- out_data and out_tag are don't-care while out_valid=0 (reset value excepted). The bench must not check them then.

Optional Feature:
- Macro: EXT_LOAD_EN.
- Defined: modes 4-7 are implemented as described, and in_word/in_off are used.
- Undefined: modes 4-7 yield out_data=0 and set err. in_word/in_off are ignored; ports remain present for a stable interface.

Decomposition:
- Shared package (ext_pkg): mode constants EXT_ZERO, EXT_SIGN, EXT_LUI, EXT_BOFF, EXT_LB, EXT_LBU, EXT_LH, EXT_LHU; the 3-bit mode width constant.
- One natural sub-module, ext_core: purely combinational mode -> data + illegal flag. ext_pipe wraps it with the handshake register and err logic.

Test Plan:
- SIGN, in_imm=16'h8001, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8001; ZERO with the same immediate -> 32'h00008001.
- LUI 16'h1234 -> 32'h12340000; BOFF 16'hFFFF -> 32'hFFFFFFFC; tag 5'd17 appears on out_tag.
- Stall: accept an item, out_ready=0 for 3 cycles -> in_ready=0 and out_* stable; then a back-to-back stream with out_ready=1 -> one result per cycle, order preserved.
- EXT_LOAD_EN defined, in_word=32'h80FF7F01:
  - LB off=2 -> 32'hFFFFFFFF; LBU off=3 -> 32'h00000080; LH off=2 -> 32'hFFFF80FF.
  - LHU off=1 -> err=1, out_data=0.
- EXT_LOAD_EN undefined, mode=4 -> out_data=0, err=1; err stays 1 through a later flush and clears only on reset.
- Flush with an in_valid accept in the same cycle -> out_valid=0 next cycle, item lost. Assert reset_n low mid-hold, between edges -> out_valid drops immediately.
